// File: rtl/tracker_pkg.sv
// Shared types and constants for the orange centroid tracker: FSM states,
// one-hot direction codes and default VGA geometry.
package tracker_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        TRACK,
        LOSING
    } tracker_state_t;

    localparam logic [2:0] DIR_NONE   = 3'b000;
    localparam logic [2:0] DIR_LEFT   = 3'b100;
    localparam logic [2:0] DIR_CENTRE = 3'b010;
    localparam logic [2:0] DIR_RIGHT  = 3'b001;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    localparam int COUNT_W = 17;
    localparam int X_W     = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_bbox_accumulator.sv
// Per-frame pixel position tracking and orange pixel statistics (count and
// horizontal bounding box), latched into outputs at each vsync falling edge.
module frame_bbox_accumulator
    import tracker_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_valid,
    input  logic               vsync,
    input  logic               is_orange,
    output logic               boundary,
    output logic [COUNT_W-1:0] closing_count,
    output logic [X_W-1:0]     closing_x_min,
    output logic [X_W-1:0]     closing_x_max,
    output logic [COUNT_W-1:0] orange_count,
    output logic [X_W-1:0]     bbox_x_min,
    output logic [X_W-1:0]     bbox_x_max
);

    localparam logic [X_W-1:0]     X_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0]     Y_LAST    = X_W'(V_ACTIVE - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic               pv_q;
    logic               vs_q;
    logic [X_W-1:0]     x;
    logic [X_W-1:0]     y;
    logic [COUNT_W-1:0] count;
    logic [X_W-1:0]     x_min;
    logic [X_W-1:0]     x_max;
    logic               line_end;
    logic               pix_hit;

    assign boundary = vs_q & ~vsync;
    assign line_end = pv_q & ~pixel_valid;
    assign pix_hit  = pixel_valid & is_orange;

    // Frame totals including the current pixel, so a pixel landing on the
    // boundary cycle still belongs to the frame being closed.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        closing_count = count;
        closing_x_min = x_min;
        closing_x_max = x_max;
        if (pix_hit) begin
            if (count != COUNT_MAX) closing_count = count + COUNT_W'(1);
            if (x < x_min)          closing_x_min = x;
            if (x > x_max)          closing_x_max = x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q         <= 1'b0;
            vs_q         <= 1'b0;
            x            <= '0;
            y            <= '0;
            count        <= '0;
            x_min        <= X_LAST;
            x_max        <= '0;
            orange_count <= '0;
            bbox_x_min   <= '0;
            bbox_x_max   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            pv_q <= pixel_valid;
            vs_q <= vsync;
            if (boundary) begin
                x            <= '0;
                y            <= '0;
                count        <= '0;
                x_min        <= X_LAST;
                x_max        <= '0;
                orange_count <= closing_count;
                bbox_x_min   <= closing_x_min;
                bbox_x_max   <= closing_x_max;
            end else begin
                count <= closing_count;
                x_min <= closing_x_min;
                x_max <= closing_x_max;
                if (line_end) begin
                    x <= '0;
                    if (y != Y_LAST) y <= y + X_W'(1);
                end else if (pixel_valid && x != X_LAST) begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/orange_centroid_tracker.sv
// Turns per-frame orange statistics into a hysteresis-filtered detection flag
// and a left/centre/right steering direction for the drive FSM.
module orange_centroid_tracker
    import tracker_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
    parameter int MIN_PIXELS     = 400,
    parameter int DEADBAND       = 64,
    parameter int CONFIRM_FRAMES = 3,
    parameter int LOSS_FRAMES    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_valid,
    input  logic               vsync,
    input  logic               is_orange,
    output logic [2:0]         direction,
    output logic               orange_detected,
    output logic               frame_done,
    output logic [COUNT_W-1:0] orange_count,
    output logic [X_W-1:0]     bbox_x_min,
    output logic [X_W-1:0]     bbox_x_max
);

    localparam int CNT_W = $clog2(max_int(CONFIRM_FRAMES, LOSS_FRAMES)) + 1;
    localparam logic [CNT_W-1:0]   CONFIRM_LAST = CNT_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W-1:0]   LOSS_LAST    = CNT_W'(LOSS_FRAMES);
    localparam logic [COUNT_W-1:0] MIN_COUNT    = COUNT_W'(MIN_PIXELS);
    localparam logic [X_W:0]       LEFT_EDGE    = (X_W + 1)'(H_ACTIVE / 2 - DEADBAND);
    localparam logic [X_W:0]       RIGHT_EDGE   = (X_W + 1)'(H_ACTIVE / 2 + DEADBAND);

    tracker_state_t     state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               boundary;
    logic [COUNT_W-1:0] closing_count;
    logic [X_W-1:0]     closing_x_min;
    logic [X_W-1:0]     closing_x_max;
    logic               hit;
    logic [X_W:0]       centre_x;
    logic [2:0]         dir_calc;

    frame_bbox_accumulator #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_accum (
        .clk           (clk),
        .rst           (rst),
        .pixel_valid   (pixel_valid),
        .vsync         (vsync),
        .is_orange     (is_orange),
        .boundary      (boundary),
        .closing_count (closing_count),
        .closing_x_min (closing_x_min),
        .closing_x_max (closing_x_max),
        .orange_count  (orange_count),
        .bbox_x_min    (bbox_x_min),
        .bbox_x_max    (bbox_x_max)
    );

    assign hit      = (closing_count >= MIN_COUNT);
    assign cnt_inc  = frame_cnt + CNT_W'(1);
    assign centre_x = ({1'b0, closing_x_min} + {1'b0, closing_x_max}) >> 1;

    always_comb begin
        dir_calc = DIR_CENTRE;
        if (centre_x < LEFT_EDGE)       dir_calc = DIR_LEFT;
        else if (centre_x > RIGHT_EDGE) dir_calc = DIR_RIGHT;
    end

    // The FSM steps on the same edge that latches the frame statistics, so
    // frame_done sees detection, direction and bbox all from one frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SEARCH;
            frame_cnt       <= '0;
            direction       <= DIR_NONE;
            orange_detected <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary) begin
                case (state)
                    SEARCH: begin
                        if (hit) begin
                            state     <= CONFIRM;
                            frame_cnt <= CNT_W'(1);
                        end
                    end
                    CONFIRM: begin
                        if (!hit) begin
                            state     <= SEARCH;
                            frame_cnt <= '0;
                        end else if (cnt_inc == CONFIRM_LAST) begin
                            state           <= TRACK;
                            frame_cnt       <= '0;
                            orange_detected <= 1'b1;
                            direction       <= dir_calc;
                        end else begin
                            frame_cnt <= cnt_inc;
                        end
                    end
                    TRACK: begin
                        if (hit) begin
                            direction <= dir_calc;
                        end else begin
                            state     <= LOSING;
                            frame_cnt <= CNT_W'(1);
                        end
                    end
                    LOSING: begin
                        if (hit) begin
                            state     <= TRACK;
                            frame_cnt <= '0;
                            direction <= dir_calc;
                        end else if (cnt_inc == LOSS_LAST) begin
                            state           <= SEARCH;
                            frame_cnt       <= '0;
                            orange_detected <= 1'b0;
                            direction       <= DIR_NONE;
                        end else begin
                            frame_cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state           <= SEARCH;
                        frame_cnt       <= '0;
                        orange_detected <= 1'b0;
                        direction       <= DIR_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_orange_centroid_tracker.sv
// Scoreboard bench: stimulus tasks queue the expected per-frame results and a
// monitor pops one entry on every frame_done pulse.
module tb_orange_centroid_tracker;
    import tracker_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_valid = 1'b0;
    logic        vsync = 1'b1;
    logic        is_orange = 1'b0;
    logic [2:0]  direction;
    logic        orange_detected;
    logic        frame_done;
    logic [16:0] orange_count;
    logic [9:0]  bbox_x_min;
    logic [9:0]  bbox_x_max;

    typedef struct {
        logic [16:0] count;
        logic [9:0]  x_min;
        logic [9:0]  x_max;
        logic        det;
        logic [2:0]  dir;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    orange_centroid_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_valid     (pixel_valid),
        .vsync           (vsync),
        .is_orange       (is_orange),
        .direction       (direction),
        .orange_detected (orange_detected),
        .frame_done      (frame_done),
        .orange_count    (orange_count),
        .bbox_x_min      (bbox_x_min),
        .bbox_x_max      (bbox_x_max)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic expect_frame(input int c, input int mn, input int mx, input bit d, input logic [2:0] dr);
        exp_t e;
        e.count = 17'(c);
        e.x_min = 10'(mn);
        e.x_max = 10'(mx);
        e.det   = d;
        e.dir   = dr;
        exp_q.push_back(e);
    endtask

    // Monitor: sample on the falling edge, one scoreboard entry per pulse.
    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame_done: got pulse, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("orange_count",    32'(orange_count),    32'(e.count));
                check("bbox_x_min",      32'(bbox_x_min),      32'(e.x_min));
                check("bbox_x_max",      32'(bbox_x_max),      32'(e.x_max));
                check("orange_detected", 32'(orange_detected), 32'(e.det));
                check("direction",       32'(direction),       32'(e.dir));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            is_orange   = 1'b0;
        end
    endtask

    task automatic line(input int len, input int x0, input int x1);
        for (int x = 0; x < len; x++) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            is_orange   = (x >= x0 && x <= x1);
        end
        idle(2);
    endtask

    task automatic end_frame();
        @(negedge clk);
        pixel_valid = 1'b0;
        is_orange   = 1'b0;
        vsync       = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        idle(3);
    endtask

    task automatic block_frame(input int x0, input int x1, input int rows);
        repeat (rows) line(x1 + 1, x0, x1);
        end_frame();
    endtask

    task automatic miss_frame();
        line(16, 1, 0);
        end_frame();
    endtask

    // Last pixel of the line (x=639) is orange and lands on the vsync fall.
    task automatic edge_pixel_frame();
        for (int x = 0; x < 639; x++) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            is_orange   = 1'b0;
        end
        @(negedge clk);
        pixel_valid = 1'b1;
        is_orange   = 1'b1;
        vsync       = 1'b0;
        @(negedge clk);
        pixel_valid = 1'b0;
        is_orange   = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        idle(3);
    endtask

    initial begin
        #(80000 * 40);
        $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(3);

        // One hit frame so the reset check has non-zero outputs to clear.
        expect_frame(600, 100, 129, 1'b0, DIR_NONE);
        block_frame(100, 129, 20);

        // Mid-frame reset with 200 orange pixels already accumulated.
        line(200, 0, 199);
        @(negedge clk);
        #5 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_orange_count", 32'(orange_count), 32'd0);
        check("rst_bbox_x_min",   32'(bbox_x_min),   32'd0);
        check("rst_bbox_x_max",   32'(bbox_x_max),   32'd0);
        check("rst_detected",     32'(orange_detected), 32'd0);
        check("rst_direction",    32'(direction),    32'd0);
        check("rst_frame_done",   32'(frame_done),   32'd0);
        check("rst_state",        32'(dut.state),    32'(SEARCH));

        expect_frame(0, 639, 0, 1'b0, DIR_NONE);
        end_frame();
        expect_frame(0, 639, 0, 1'b0, DIR_NONE);
        miss_frame();

        // Three confirming hits on the left.
        expect_frame(600, 100, 129, 1'b0, DIR_NONE);
        block_frame(100, 129, 20);
        expect_frame(600, 100, 129, 1'b0, DIR_NONE);
        block_frame(100, 129, 20);
        expect_frame(600, 100, 129, 1'b1, DIR_LEFT);
        block_frame(100, 129, 20);

        // Exactly MIN_PIXELS on the right, then centre.
        expect_frame(400, 500, 539, 1'b1, DIR_RIGHT);
        block_frame(500, 539, 10);
        expect_frame(400, 300, 339, 1'b1, DIR_CENTRE);
        block_frame(300, 339, 10);

        // Three misses (one at MIN_PIXELS-1) then a hit recovers tracking.
        expect_frame(0, 639, 0, 1'b1, DIR_CENTRE);
        miss_frame();
        expect_frame(399, 300, 320, 1'b1, DIR_CENTRE);
        block_frame(300, 320, 19);
        expect_frame(0, 639, 0, 1'b1, DIR_CENTRE);
        miss_frame();
        expect_frame(600, 100, 129, 1'b1, DIR_LEFT);
        block_frame(100, 129, 20);

        // Four consecutive misses drop detection.
        expect_frame(0, 639, 0, 1'b1, DIR_LEFT);
        miss_frame();
        expect_frame(0, 639, 0, 1'b1, DIR_LEFT);
        miss_frame();
        expect_frame(0, 639, 0, 1'b1, DIR_LEFT);
        miss_frame();
        expect_frame(0, 639, 0, 1'b0, DIR_NONE);
        miss_frame();

        // Alternating hit/miss never confirms.
        for (int i = 0; i < 2; i++) begin
            expect_frame(600, 100, 129, 1'b0, DIR_NONE);
            block_frame(100, 129, 20);
            expect_frame(0, 639, 0, 1'b0, DIR_NONE);
            miss_frame();
        end

        // Orange pixel on the boundary cycle, then a fresh accumulator.
        expect_frame(1, 639, 639, 1'b0, DIR_NONE);
        edge_pixel_frame();
        expect_frame(10, 0, 9, 1'b0, DIR_NONE);
        block_frame(0, 9, 1);

        idle(10);
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/orange_centroid_tracker.md
Name: orange_centroid_tracker

Overview:
- Consumes the per-pixel is_orange flag produced by the colour threshold stage, in lock-step with the VGA active-area strobe and vsync.
- Builds a per-frame bounding box and pixel count of orange pixels.
- At each frame boundary, publishes a filtered direction (left/centre/right) and an orange_detected flag to the drive FSM.
- Applies frame-count hysteresis so single noisy frames do not toggle the drive state.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- MIN_PIXELS, 400, minimum orange pixels for a frame to count as a hit.
- DEADBAND, 64, half-width in pixels of the centre zone around H_ACTIVE/2.
- CONFIRM_FRAMES, 3, consecutive hit frames required to assert detection.
- LOSS_FRAMES, 4, consecutive miss frames required to drop detection.

Ports:
- clk  in  1  pixel clock (25 MHz VGA domain).
- rst  in  1  asynchronous, active-high reset.
- pixel_valid  in  1  high during active display area; one pixel per cycle.
- vsync  in  1  VGA vertical sync, active-low.
- is_orange  in  1  classification of the current pixel; qualified by pixel_valid.
- direction  out  3  one-hot {left, centre, right}; 3'b000 when not detected.
- orange_detected  out  1  filtered detection flag.
- frame_done  out  1  single-cycle pulse when results update.
- orange_count  out  17  orange pixel count of the last completed frame (saturating).
- bbox_x_min  out  10  left edge of the last frame's bounding box.
- bbox_x_max  out  10  right edge of the last frame's bounding box.

Behaviour:
- Reset values: all outputs 0; bbox_x_min accumulator = H_ACTIVE-1; bbox_x_max accumulator = 0; FSM in SEARCH.
- x counter:
  - Increments on each pixel_valid cycle.
  - Clears on the pixel_valid falling edge (registered previous value).
  - The y counter increments on that same edge.
  - Both counters clear at the frame boundary.
  - x saturates at H_ACTIVE-1 if pixel_valid exceeds the line length.
- Accumulation: when pixel_valid && is_orange:
  - count += 1, saturating at 2^17-1.
  - x_min = min(x_min, x); x_max = max(x_max, x).
- Frame boundary = vsync falling edge (registered vsync, 1 cycle of detection latency). On that cycle:
  - Latch count, x_min and x_max into the outputs.
  - Reset the accumulators.
  - Step the FSM.
  - frame_done pulses the next cycle, with all outputs already updated.
- If pixel_valid && is_orange coincides with the boundary cycle, the pixel belongs to the closing frame (included before latch).
- hit = (latched count >= MIN_PIXELS).
- FSM (a single counter frame_cnt, width clog2(max(CONFIRM_FRAMES, LOSS_FRAMES))+1):
  - SEARCH: hit -> CONFIRM with frame_cnt=1; else stay.
  - CONFIRM: hit -> frame_cnt+1, and -> TRACK when frame_cnt+1 == CONFIRM_FRAMES; miss -> SEARCH with frame_cnt=0.
  - TRACK: hit -> stay; miss -> LOSING with frame_cnt=1.
  - LOSING: hit -> TRACK with frame_cnt=0; miss -> frame_cnt+1, and -> SEARCH when frame_cnt+1 == LOSS_FRAMES.
- orange_detected = 1 in TRACK and LOSING; registered, and updates on the same cycle as the other latched outputs.
- Direction:
  - centre_x = (x_min + x_max) >> 1, computed 11 bits wide, no overflow.
  - left when centre_x < H_ACTIVE/2 - DEADBAND.
  - right when centre_x > H_ACTIVE/2 + DEADBAND.
  - centre otherwise.
  - In LOSING, direction holds its last TRACK value; in SEARCH/CONFIRM it is 000.
- Zero-hit frame: bbox outputs are latched as x_min=H_ACTIVE-1, x_max=0; direction is not computed from them (the frame is a miss).
- Asynchronous reset mid-frame discards partial accumulation; the first full frame after reset starts at the next vsync falling edge.
- A missing vsync does not wrap counters; y saturates at V_ACTIVE-1.

Decomposition:
- Shared package tracker_pkg holds:
  - tracker_state_t enum {SEARCH, CONFIRM, TRACK, LOSING}.
  - Direction one-hot constants DIR_NONE=3'b000, DIR_LEFT=3'b100, DIR_CENTRE=3'b010, DIR_RIGHT=3'b001.
  - Default H_ACTIVE/V_ACTIVE constants.
- One natural sub-module: frame_bbox_accumulator (x/y counters, count, min/max, boundary latch).
- The top of the block holds the FSM and direction logic.

Test Plan:
- Reset mid-frame with 200 orange pixels injected -> all outputs 0, FSM SEARCH; the next full frame with 0 orange pixels gives frame_done with orange_count=0, orange_detected=0.
- 3 frames each with a 30x20 orange block at x=100..129 -> orange_detected rises on the 3rd frame_done, direction=100 (centre_x=114 < 256), orange_count=600.
- In TRACK, a block at x=500..539 -> direction=001 after 1 frame; a block at x=300..339 -> direction=010 (centre_x=319).
- In TRACK, 3 miss frames then 1 hit frame -> detection stays 1 and direction holds; 4 consecutive misses -> orange_detected=0, direction=000 on the 4th frame_done.
- Frames alternating hit/miss from SEARCH -> never reach TRACK; orange_detected stays 0.
- Orange pixel on the exact vsync falling-edge cycle at x=639 -> counted in the closing frame; bbox_x_max=639; the next frame's accumulator starts at 0.
